imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Boot-time instruction-memory writer for xgriscv_sc. It takes a framed byte
//   stream, packs the payload into little-endian 32-bit words and writes them
//   to consecutive imem words starting at 0. It holds the core in reset until
//   a frame passes its checksum.
// PARAMETERS
//   ADDR_WIDTH  8     imem word-address width; capacity = 2**ADDR_WIDTH words
//   SYNC_BYTE   8'hA5 frame start marker
// PORTS
//   clk         in   1            rising-edge clock
//   rstn        in   1            asynchronous active-low reset
//   in_valid    in   1            byte-stream valid
//   in_ready    out  1            byte-stream ready; a byte transfers when valid & ready at clk rise
//   in_data     in   8            stream byte
//   imem_we     out  1            imem word write enable, 1-cycle pulse
//   imem_addr   out  ADDR_WIDTH   imem word index
//   imem_wdata  out  32           imem write data
//   core_rstn   out  1            core reset, active low; high only after a good load
//   done        out  1            level; last frame loaded and checksum matched
//   error       out  1            level; last frame rejected
// BEHAVIOUR
//   Frame: SYNC_BYTE, LEN[7:0], LEN[15:8], LEN*4 payload bytes (LSB first per
//     word), CSUM. CSUM is the XOR of all payload bytes.
//   Reset (async, rstn=0): state=SYNC, in_ready=1, imem_we=0, imem_addr=0,
//     imem_wdata=0, core_rstn=0, done=0, error=0, checksum acc=0, byte count=0.
//   States and transitions, one per accepted byte:
//     SYNC : SYNC_BYTE -> LEN0; any other byte is discarded
//     LEN0 : latch LEN[7:0] -> LEN1
//     LEN1 : latch LEN[15:8]
//            LEN > 2**ADDR_WIDTH -> ERR, with no imem writes
//            LEN == 0 -> CSUM
//            otherwise -> DATA
//     DATA : shift the byte into a 32-bit assembly register, XOR it into acc.
//            On the 4th byte of a word, the next cycle has imem_we=1,
//            imem_addr=word index and imem_wdata=assembled word.
//            After the last word -> CSUM.
//     CSUM : byte == acc -> DONE; otherwise -> ERR
//     DONE : done=1, core_rstn=1 from the cycle after the CSUM accept
//     ERR  : error=1, core_rstn=0
//   Restart: in DONE or ERR, an accepted SYNC_BYTE
//     - clears done, error and acc, and resets the word index to 0;
//     - drives core_rstn=0 in the cycle after the accept;
//     - moves to LEN0.
//     Other bytes in DONE or ERR are discarded with no state change.
//   Backpressure: in_ready=0 exactly in the cycle imem_we=1; it is 1 at all
//     other times. At most one write is in flight.
//   in_valid gaps are allowed anywhere; byte position is counted only on transfers.
//   Word index increments after each write. It never wraps: the LEN check
//     bounds it to <= 2**ADDR_WIDTH-1.
//   The first imem word is index 0, i.e. byte address 0.
//   imem_addr and imem_wdata hold their last values when imem_we=0.
//   Reset mid-frame: everything returns to reset values. Partially written
//     imem content is not cleared. The next frame starts at index 0.
//   Outputs are registered; no combinational path from in_* to imem_*.
// TESTING
//   T1 good frame: A5 03 00 93 02 00 00 13 03 00 00 B7 F3 FF FF C5
//      -> writes [0]=00000293, [1]=00000313, [2]=FFFFF3B7;
//         done=1, core_rstn=1, error=0
//   T2 empty frame: A5 00 00 00 -> no imem_we; done=1, core_rstn=1
//   T3 oversize, ADDR_WIDTH=8: A5 01 01 -> error=1 after LEN1 accept;
//      no writes; core_rstn=0; following bytes discarded
//   T4 bad checksum: T1 with final byte C4 -> 3 writes occur; error=1,
//      done=0, core_rstn=0. Then the T1 frame -> done=1, core_rstn=1
//   T5 stalls + backpressure: T1 with random in_valid gaps
//      -> identical writes; in_ready=0 exactly on the 3 write cycles
//   T6 reset mid-DATA: pull rstn low after 6 payload bytes
//      -> all outputs at reset values immediately; a fresh T1 then writes from index 0

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write bus of the boot loader, bundled as one
// interface. The slave modport is the loader's view, master is the peer's view.
//
// Handshake: a stream byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_data must be stable while in_valid is 1 and not yet
// accepted. imem_we is a one-cycle pulse qualifying imem_addr/imem_wdata.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time imem writer: parses a framed byte stream (sync, 16-bit word count,
// little-endian payload words, XOR checksum), writes the words to imem from
// index 0 and releases the core reset only after a frame checks out.
module imem_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic clk,
  input  logic rstn,
  imem_loader_if.slave bus,
  output logic core_rstn,
  output logic done,
  output logic error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int unsigned CAP = 1 << ADDR_WIDTH;

  state_t              state;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [7:0]          acc;
  logic [1:0]          byte_cnt;
  logic [23:0]         asm_reg;   // first three bytes of the word being built
  logic [ADDR_WIDTH:0] word_idx;  // one extra bit: may reach CAP after last write
  logic                xfer;

  assign xfer      = bus.in_valid && bus.in_ready;
  // The only stall is the write cycle, so ready is simply the inverse of the
  // registered write strobe; nothing from in_* reaches it combinationally.
  assign bus.in_ready = ~bus.imem_we;
  assign state_dbg = state;

  // Frame parser, word packer and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_SYNC;
      len_lo         <= '0;
      len            <= '0;
      acc            <= '0;
      byte_cnt       <= '0;
      asm_reg        <= '0;
      word_idx       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_rstn      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_SYNC: begin
            if (bus.in_data == SYNC_BYTE) begin
              acc      <= '0;
              byte_cnt <= '0;
              word_idx <= '0;
              state    <= S_LEN0;
            end
          end
          S_LEN0: begin
            len_lo <= bus.in_data;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            len <= {bus.in_data, len_lo};
            if (32'({bus.in_data, len_lo}) > CAP) begin
              error <= 1'b1;
              state <= S_ERR;
            end else if ({bus.in_data, len_lo} == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            acc      <= acc ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_reg  <= {bus.in_data, asm_reg[23:8]};
            if (byte_cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              bus.imem_wdata <= {bus.in_data, asm_reg};
              word_idx       <= word_idx + 1'b1;
              if ((32'(word_idx) + 32'd1) == 32'(len)) begin
                state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (bus.in_data == acc) begin
              done      <= 1'b1;
              core_rstn <= 1'b1;
              state     <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
          S_DONE, S_ERR: begin
            // Only a new sync byte restarts; everything else is dropped.
            if (bus.in_data == SYNC_BYTE) begin
              done      <= 1'b0;
              error     <= 1'b0;
              core_rstn <= 1'b0;
              acc       <= '0;
              byte_cnt  <= '0;
              word_idx  <= '0;
              state     <= S_LEN0;
            end
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule
